// File: rtl/switch_stim_seq_pkg.sv
// Shared types and constants for the switch stimulus sequencer.
// Vector bit positions map directly onto the drive pins.
package switch_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int HOLD_W  = 8;

  localparam int SRC_BIT = 0;
  localparam int NG_BIT  = 1;
  localparam int PG_BIT  = 2;

  function automatic logic resp_differs(
    input logic a,
    input logic b
  );
    return a != b;
  endfunction

endpackage

// File: rtl/switch_stim_seq_if.sv
// Stimulus / response bundle between a sweep controller
// and the test fixture holding the two switches.
interface switch_stim_seq_if;

  logic       start;
  logic       resp_a;
  logic       resp_b;
  logic       source;
  logic       n_gate;
  logic       p_gate;
  logic       busy;
  logic       done;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_mis_idx;
  logic       first_mis_valid;

  modport master (
    output start,
    output resp_a,
    output resp_b,
    input  source,
    input  n_gate,
    input  p_gate,
    input  busy,
    input  done,
    input  mismatch_cnt,
    input  first_mis_idx,
    input  first_mis_valid
  );

  modport slave (
    input  start,
    input  resp_a,
    input  resp_b,
    output source,
    output n_gate,
    output p_gate,
    output busy,
    output done,
    output mismatch_cnt,
    output first_mis_idx,
    output first_mis_valid
  );

endinterface

// File: rtl/switch_stim_seq_hold_cnt.sv
// Per-vector hold timer; last flags the final hold cycle,
// which is the only cycle responses may be sampled.
module stim_hold_cnt
  import switch_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [HOLD_W-1:0] cnt;

  assign last = (cnt == HOLD_W'(HOLD_CYCLES - 1));

  // count 0..H-1 while enabled, wrapping after the last cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/switch_stim_seq.sv
// Sweeps the 8 source/gate combinations across two switches
// and records how many vectors gave differing drain responses.
module switch_stim_seq
  import switch_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  switch_stim_seq_if.slave bus
);

  state_t     state;
  state_t     state_nx;
  logic [2:0] vec;
  logic [2:0] vec_nx;
  logic [2:0] drv;
  logic [3:0] mcnt;
  logic [2:0] fidx;
  logic       fvld;
  logic       run;
  logic       last;
  logic       accept;
  logic       sample;
  logic       mis;

  assign run    = (state == RUN);
  assign accept = (state == IDLE) && bus.start;
  assign sample = run && last;
  assign mis    = sample &&
                  resp_differs(bus.resp_a, bus.resp_b);

  stim_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (run),
    .last  (last)
  );

  // next state and next vector
  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          vec_nx   = '0;
        end
      end
      RUN: begin
        if (sample) begin
          vec_nx = vec + 3'd1;
          if (vec == 3'(NUM_VEC - 1)) begin
            state_nx = FIN;
          end
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state, vector and registered drive pins
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      drv   <= '0;
    end else begin
      state <= state_nx;
      vec   <= vec_nx;
      drv   <= (state_nx == RUN) ? vec_nx : '0;
    end
  end

  // mismatch count and first-mismatch capture
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      mcnt <= '0;
      fidx <= '0;
      fvld <= 1'b0;
    end else if (mis) begin
      if (mcnt != 4'(NUM_VEC)) begin
        mcnt <= mcnt + 4'd1;
      end
      if (!fvld) begin
        fidx <= vec;
        fvld <= 1'b1;
      end
    end
  end

  assign bus.source          = drv[SRC_BIT];
  assign bus.n_gate          = drv[NG_BIT];
  assign bus.p_gate          = drv[PG_BIT];
  assign bus.busy            = run;
  assign bus.done            = (state == FIN);
  assign bus.mismatch_cnt    = mcnt;
  assign bus.first_mis_idx   = fidx;
  assign bus.first_mis_valid = fvld;

endmodule

// File: tb/tb_switch_stim_seq.sv
// Directed bench: three sequencers at H=1, H=3 and H=2,
// responses derived from the drive pins per test mode.
module tb_switch_stim_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic st   [3];
  int   rmode[3];
  logic glt  [3];

  logic [2:0] drv_o [3];
  logic       busy_o[3];
  logic       done_o[3];
  logic [3:0] mcnt_o[3];
  logic [2:0] fidx_o[3];
  logic       fv_o  [3];

  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic rb(
    input int       m,
    input logic     s,
    input logic [2:0] d,
    input logic     g
  );
    case (m)
      1:       return (d == 3'd5) ? ~s : s;
      2:       return ~s;
      3:       return g ? ~s : s;
      default: return s;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    switch_stim_seq_if bus();
    logic [2:0] d;
    assign d = {bus.p_gate, bus.n_gate, bus.source};
    assign bus.start  = st[g];
    assign bus.resp_a = bus.source;
    assign bus.resp_b = rb(rmode[g], bus.source, d, glt[g]);
    assign drv_o[g]   = d;
    assign busy_o[g]  = bus.busy;
    assign done_o[g]  = bus.done;
    assign mcnt_o[g]  = bus.mismatch_cnt;
    assign fidx_o[g]  = bus.first_mis_idx;
    assign fv_o[g]    = bus.first_mis_valid;
    switch_stim_seq #(
      .HOLD_CYCLES(H)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(
    input string tag,
    input int    i,
    input int    h,
    input int    emc,
    input int    eidx,
    input int    efv,
    input bit    gl
  );
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < h; j++) begin
        chk({tag, " drv"}, drv_o[i], k);
        chk({tag, " busy"}, busy_o[i], 1);
        chk({tag, " done_early"}, done_o[i], 0);
        glt[i] = gl && (j == 0);
        tick();
      end
    end
    glt[i] = 1'b0;
    chk({tag, " done"}, done_o[i], 1);
    chk({tag, " busy_fin"}, busy_o[i], 0);
    chk({tag, " drv_fin"}, drv_o[i], 0);
    chk({tag, " mcnt"}, mcnt_o[i], emc);
    chk({tag, " fv"}, fv_o[i], efv);
    if (efv != 0) chk({tag, " fidx"}, fidx_o[i], eidx);
    tick();
    chk({tag, " done_pulse"}, done_o[i], 0);
    tick();
    tick();
    chk({tag, " mcnt_hold"}, mcnt_o[i], emc);
    chk({tag, " fv_hold"}, fv_o[i], efv);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i]    = 1'b0;
      rmode[i] = 0;
      glt[i]   = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst drv", drv_o[i], 0);
      chk("rst busy", busy_o[i], 0);
      chk("rst done", done_o[i], 0);
      chk("rst mcnt", mcnt_o[i], 0);
      chk("rst fv", fv_o[i], 0);
    end

    // H=1, identical responses: done at T+9
    run_sweep("h1_eq", 0, 1, 0, 0, 0, 1'b0);

    // H=3, mismatch only on vector 5: done at T+25
    rmode[1] = 1;
    run_sweep("h3_v5", 1, 3, 1, 5, 1, 1'b0);

    // H=2, every vector mismatches: saturates at 8
    rmode[2] = 2;
    run_sweep("h2_all", 2, 2, 8, 0, 1, 1'b0);

    // H=2, mismatch only in first hold cycle
    rmode[2] = 3;
    run_sweep("h2_glitch", 2, 2, 0, 0, 0, 1'b1);

    // reset during vector 4 with mismatches pending
    rmode[0] = 2;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("rst4 drv", drv_o[0], 4);
    chk("rst4 mcnt_pre", mcnt_o[0], 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst4 drv", drv_o[0], 0);
    chk("rst4 busy", busy_o[0], 0);
    chk("rst4 done", done_o[0], 0);
    chk("rst4 mcnt", mcnt_o[0], 0);
    chk("rst4 fv", fv_o[0], 0);
    for (int c = 0; c < 10; c++) begin
      chk("rst4 no_done", done_o[0], 0);
      tick();
    end
    rmode[0] = 0;
    run_sweep("rst4_again", 0, 1, 0, 0, 0, 1'b0);

    // mid-sweep start ignored; start held through FIN
    rmode[2] = 2;
    st[2] = 1'b1;
    tick();
    st[2] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("hold drv", drv_o[2], (c - 1) / 2);
      chk("hold done_early", done_o[2], 0);
      st[2] = (c == 4) || (c == 16);
      tick();
    end
    chk("hold done", done_o[2], 1);
    chk("hold mcnt", mcnt_o[2], 8);
    tick();
    chk("hold idle_busy", busy_o[2], 0);
    chk("hold idle_done", done_o[2], 0);
    chk("hold idle_mcnt", mcnt_o[2], 8);
    rmode[2] = 0;
    tick();
    st[2] = 1'b0;
    chk("hold2 busy", busy_o[2], 1);
    chk("hold2 mcnt", mcnt_o[2], 0);
    chk("hold2 fv", fv_o[2], 0);
    for (int c = 19; c <= 34; c++) begin
      chk("hold2 drv", drv_o[2], (c - 19) / 2);
      chk("hold2 done_early", done_o[2], 0);
      tick();
    end
    chk("hold2 done", done_o[2], 1);
    chk("hold2 mcnt_end", mcnt_o[2], 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/switch_stim_seq.md
SWITCH_STIM_SEQ -- requirements
Module: switch_stim_seq

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1, number of clock cycles each stimulus vector is held; legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request one full 8-vector sweep; sampled only in IDLE.
REQ-005 The block SHALL have port resp_a  input  1  drain response of first switch under test.
REQ-006 The block SHALL have port resp_b  input  1  drain response of second switch under test.
REQ-007 The block SHALL have port source  output  1  registered source drive, equal to vector bit 0.
REQ-008 The block SHALL have port n_gate  output  1  registered n-gate drive, equal to vector bit 1.
REQ-009 The block SHALL have port p_gate  output  1  registered p-gate drive, equal to vector bit 2.
REQ-010 The block SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking sweep completion.
REQ-012 The block SHALL have port mismatch_cnt  output  4  count of vectors where resp_a != resp_b; range 0..8.
REQ-013 The block SHALL have port first_mis_idx  output  3  vector index of the first mismatch.
REQ-014 The block SHALL have port first_mis_valid  output  1  high once first_mis_idx holds a captured value.

Function
REQ-015 The block SHALL implement states IDLE, RUN and FIN.
REQ-016 State transitions SHALL be: IDLE -> RUN on start=1; RUN -> FIN after the sample of vector 7; FIN -> IDLE unconditionally after one cycle.
REQ-017 In IDLE, source, n_gate and p_gate SHALL all be 0, and busy and done SHALL be 0.
REQ-018 On the IDLE cycle with start=1, the block SHALL clear vec, hold_cnt, mismatch_cnt and first_mis_valid.
REQ-019 In the cycle after start, busy SHALL be 1 and {p_gate,n_gate,source} SHALL equal 3'd0.
REQ-020 Vector k (0..7) SHALL be driven on cycles T+1+k*H through T+k*H+H, where T is the start cycle and H is HOLD_CYCLES.
REQ-021 Vectors SHALL be applied in ascending order 0..7 with no gaps and no repeats.
REQ-022 Responses SHALL be sampled only in the last hold cycle of each vector (hold_cnt == H-1), never earlier.
REQ-023 A sampled mismatch (resp_a != resp_b) SHALL increment mismatch_cnt by 1 on the next edge.
REQ-024 mismatch_cnt SHALL saturate at 8 and SHALL never wrap.
REQ-025 On the first mismatch of a sweep, first_mis_idx SHALL capture vec and first_mis_valid SHALL be set; later mismatches SHALL leave both unchanged.
REQ-026 In FIN, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and drives SHALL return to 0.
REQ-027 Latency from start to done SHALL be 8*H+1 cycles.
REQ-028 start asserted in RUN or FIN SHALL be ignored, with no queuing.
REQ-029 start held continuously SHALL begin a new sweep on the cycle after FIN.
REQ-030 mismatch_cnt, first_mis_idx and first_mis_valid SHALL hold their values after a sweep until the next accepted start or reset.
REQ-031 With H=1, vec SHALL advance every cycle and every cycle of RUN SHALL be a sample cycle.

Reset
REQ-032 rst=1 SHALL force IDLE, vec=0, hold_cnt=0 and all outputs 0 on the next edge.
REQ-033 rst SHALL take priority over start and over any in-flight sweep.
REQ-034 A reset during RUN SHALL abort the sweep with no done pulse, and the partial mismatch results SHALL be discarded.

Structure
REQ-035 Package switch_stim_pkg SHALL hold the state enum, NUM_VEC=8, and the bit positions SRC_BIT=0, NG_BIT=1, PG_BIT=2.
REQ-036 The hold timer SHALL be the sub-module stim_hold_cnt.
REQ-037 stim_hold_cnt SHALL have inputs clk, rst, clear, en and output last (hold_cnt == H-1).
REQ-038 The vector register, FSM and mismatch logic SHALL remain in switch_stim_seq.

Verification
REQ-039 Bench SHALL cover: H=1, resp_a=resp_b=source -> vectors 0..7 on consecutive cycles, done at T+9, mismatch_cnt=0, first_mis_valid=0.
REQ-040 Bench SHALL cover: H=3, resp_b=~resp_a only while vec=5 -> mismatch_cnt=1, first_mis_idx=5, done at T+25.
REQ-041 Bench SHALL cover: H=2, resp_b=~resp_a always -> mismatch_cnt=8, first_mis_idx=0, no wrap.
REQ-042 Bench SHALL cover: rst asserted during vector 4 -> all outputs 0 next cycle, no done pulse, next start restarts at vector 0.
REQ-043 Bench SHALL cover: start pulsed mid-sweep and held high through FIN -> the mid-sweep pulse is ignored, and a second sweep begins the cycle after done with counts cleared.
REQ-044 Bench SHALL cover: H=2, responses glitched to a mismatch in the first hold cycle only -> no mismatch counted.
